// File: rtl/lock_pkg.sv
// Shared definitions for the combination lock and its supervisory controller.
//   LS_*         : lock FSM state encodings, shared with combination_lock_fsm
//   ctl_state_e  : supervisory controller states
//   is_partial() : true when the lock FSM is part-way through a code entry
package lock_pkg;

  localparam logic [1:0] LS_IDLE   = 2'b00;
  localparam logic [1:0] LS_FIRST  = 2'b01;
  localparam logic [1:0] LS_SECOND = 2'b10;
  localparam logic [1:0] LS_OPEN   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_OPEN,
    ST_LOCKOUT
  } ctl_state_e;

  function automatic logic is_partial(input logic [1:0] ls);
    return (ls == LS_FIRST) || (ls == LS_SECOND);
  endfunction

endpackage

// File: rtl/key_pulse_sync.sv
// Two-flop synchronizer plus registered rising-edge detector for one button.
//   clk_i   : system clock
//   rst_ni  : synchronous active-low reset (clears every stage)
//   key_i   : raw asynchronous button
//   en_i    : forwarding enable; the pipeline keeps running when low
//   pulse_o : registered one-cycle strobe, high from edge N+2 to N+3
//             when the key is first sampled high at edge N
module key_pulse_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  input  logic en_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, seen_q, pulse_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      seen_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      // seen_q tracks the key even while disabled, so a key held across
      // a state change cannot produce a late strobe.
      seen_q  <= sync2_q;
      pulse_q <= en_i & sync2_q & ~seen_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/lock_access_controller.sv
// Supervisory controller between raw push-buttons and combination_lock_fsm.
//   Clk, Reset_n          : clock, synchronous active-low reset
//   Key1, Key2            : raw buttons
//   ManualRelock          : level request to relock while open
//   LockState             : lock FSM state
//   Key1Pulse, Key2Pulse  : one-cycle key strobes to the lock FSM
//   LockReset             : active-high reset to the lock FSM
//   FailCount             : failures since last success or lockout exit
//   Lockout               : high while locked out
//   Alarm                 : sticky alarm after repeated lockouts
module lock_access_controller
  import lock_pkg::*;
#(
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned RELOCK_CYCLES  = 500,
  parameter int unsigned MAX_LOCKOUTS   = 2
) (
  input  logic                                Clk,
  input  logic                                Reset_n,
  input  logic                                Key1,
  input  logic                                Key2,
  input  logic                                ManualRelock,
  input  logic [1:0]                          LockState,
  output logic                                Key1Pulse,
  output logic                                Key2Pulse,
  output logic                                LockReset,
  output logic [$clog2(MAX_FAILS+1)-1:0]      FailCount,
  output logic                                Lockout,
  output logic                                Alarm
);

  localparam int unsigned FW   = $clog2(MAX_FAILS + 1);
  localparam int unsigned LW   = $clog2(MAX_LOCKOUTS + 1);
  localparam int unsigned TMAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES : RELOCK_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX);

  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
  localparam logic [LW-1:0] LOCK_MAX  = LW'(MAX_LOCKOUTS);
  localparam logic [TW-1:0] LO_LAST   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] RL_LAST   = TW'(RELOCK_CYCLES - 1);

  ctl_state_e    state_q, state_d;
  logic [1:0]    prev_q;
  logic [FW-1:0] fail_q, fail_d;
  logic [LW-1:0] locks_q, locks_d, locks_inc;
  logic [TW-1:0] timer_q, timer_d;
  logic          alarm_q, alarm_d;
  logic          lr_q, lr_d, lr_prev_q;
  logic          lockout_q, lockout_d;
  logic          failure, success, relock, fwd_en;

  always_comb begin
    state_d   = state_q;
    fail_d    = fail_q;
    locks_d   = locks_q;
    alarm_d   = alarm_q;
    timer_d   = '0;
    relock    = 1'b0;
    locks_inc = (locks_q == LOCK_MAX) ? locks_q : locks_q + LW'(1);
    // A drop to idle right after we reset the lock is our doing, not a failure.
    failure   = is_partial(prev_q) && (LockState == LS_IDLE) && !lr_prev_q;
    success   = (LockState == LS_OPEN);

    unique case (state_q)
      ST_IDLE: begin
        if (LockState == LS_FIRST) state_d = ST_ENTRY;
      end
      ST_ENTRY: begin
        if (failure) begin
          if (fail_q == FAIL_LAST) begin
            fail_d  = FAIL_MAX;
            locks_d = locks_inc;
            if (locks_inc == LOCK_MAX) alarm_d = 1'b1;
            state_d = ST_LOCKOUT;
          end else begin
            fail_d  = fail_q + FW'(1);
            state_d = ST_IDLE;
          end
        end else if (success) begin
          fail_d  = '0;
          locks_d = '0;
          state_d = ST_OPEN;
        end
      end
      ST_OPEN: begin
        fail_d  = '0;
        locks_d = '0;
        // Manual request and expiry share one exit path, so one pulse only.
        if (ManualRelock || (timer_q == RL_LAST)) begin
          relock  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == LO_LAST) begin
          fail_d  = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    lockout_d = (state_d == ST_LOCKOUT);
    lr_d      = lockout_d || relock;
    fwd_en    = (state_d == ST_IDLE) || (state_d == ST_ENTRY);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      prev_q    <= LS_IDLE;
      fail_q    <= '0;
      locks_q   <= '0;
      timer_q   <= '0;
      alarm_q   <= 1'b0;
      lr_q      <= 1'b1;
      lr_prev_q <= 1'b1;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= LockState;
      fail_q    <= fail_d;
      locks_q   <= locks_d;
      timer_q   <= timer_d;
      alarm_q   <= alarm_d;
      lr_q      <= lr_d;
      lr_prev_q <= lr_q;
      lockout_q <= lockout_d;
    end
  end

  key_pulse_sync u_key1 (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .key_i   (Key1),
    .en_i    (fwd_en),
    .pulse_o (Key1Pulse)
  );

  key_pulse_sync u_key2 (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .key_i   (Key2),
    .en_i    (fwd_en),
    .pulse_o (Key2Pulse)
  );

  assign LockReset = lr_q;
  assign FailCount = fail_q;
  assign Lockout   = lockout_q;
  assign Alarm     = alarm_q;

endmodule

// File: tb/tb_lock_access_controller.sv
module tb_lock_access_controller;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Key1 = 1'b0, Key2 = 1'b0, ManualRelock = 1'b0;
  logic [1:0] LockState = 2'b00;
  logic       Key1Pulse, Key2Pulse, LockReset, Lockout, Alarm;
  logic [1:0] FailCount;

  int checks = 0;
  int errors = 0;

  lock_access_controller #(
    .MAX_FAILS      (3),
    .LOCKOUT_CYCLES (1000),
    .RELOCK_CYCLES  (500),
    .MAX_LOCKOUTS   (2)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Key1         (Key1),
    .Key2         (Key2),
    .ManualRelock (ManualRelock),
    .LockState    (LockState),
    .Key1Pulse    (Key1Pulse),
    .Key2Pulse    (Key2Pulse),
    .LockReset    (LockReset),
    .FailCount    (FailCount),
    .Lockout      (Lockout),
    .Alarm        (Alarm)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One failed attempt: lock goes to first-digit-ok for a cycle, then back to idle.
  task automatic do_fail();
    LockState = 2'b01; tick();
    LockState = 2'b00; tick();
  endtask

  // Counts cycles with Lockout high (current one included); optionally presses keys.
  task automatic wait_lockout(input bit press, output int hi, output int pulses, output int lr_bad);
    hi = 1; pulses = 0; lr_bad = 0;
    for (int i = 0; i < 1100 && Lockout; i++) begin
      if (press) begin
        if (i == 100) Key1 = 1'b1;
        if (i == 140) Key1 = 1'b0;
        if (i == 500) begin Key1 = 1'b1; Key2 = 1'b1; end
        if (i == 520) begin Key1 = 1'b0; Key2 = 1'b0; end
      end
      tick();
      if (Key1Pulse || Key2Pulse) pulses++;
      if (Lockout) begin
        hi++;
        if (!LockReset) lr_bad++;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({Key1Pulse, Key2Pulse, LockReset, FailCount, Lockout, Alarm} !== 7'b0010000) begin
      errors++;
      $display("FAIL %s: got k1=%0b k2=%0b lr=%0b fc=%0d lo=%0b al=%0b expected 0 0 1 0 0 0",
               tag, Key1Pulse, Key2Pulse, LockReset, FailCount, Lockout, Alarm);
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    tick(); tick();
    check_reset_values("reset_values");
    Reset_n = 1'b1;
    checks++;
    if (LockReset !== 1'b1) begin errors++; $display("FAIL lr_first_cycle: got %0b expected 1", LockReset); end
    tick();
    checks++;
    if (LockReset !== 1'b0) begin errors++; $display("FAIL lr_release: got %0b expected 0", LockReset); end
  endtask

  task automatic test_key_pulse();
    int n1, n2, first;
    n1 = 0; n2 = 0; first = -1;
    Key1 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (Key1Pulse) begin n1++; if (first < 0) first = i; end
      if (Key2Pulse) n2++;
    end
    Key1 = 1'b0;
    repeat (4) tick();
    checks++;
    if (n1 !== 1) begin errors++; $display("FAIL key1_count: got %0d expected 1", n1); end
    checks++;
    if (first !== 3) begin errors++; $display("FAIL key1_latency: got %0d expected 3", first); end
    checks++;
    if (n2 !== 0) begin errors++; $display("FAIL key2_idle: got %0d expected 0", n2); end
    // Simultaneous press: both strobes on the same cycle.
    Key1 = 1'b1; Key2 = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({Key1Pulse, Key2Pulse} !== 2'b11) begin errors++; $display("FAIL both_keys: got %b expected 11", {Key1Pulse, Key2Pulse}); end
    tick();
    checks++;
    if ({Key1Pulse, Key2Pulse} !== 2'b00) begin errors++; $display("FAIL both_keys_end: got %b expected 00", {Key1Pulse, Key2Pulse}); end
    Key1 = 1'b0; Key2 = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_lockout();
    int hi, pulses, lr_bad;
    do_fail();
    checks++;
    if (FailCount !== 2'd1) begin errors++; $display("FAIL fail_1: got %0d expected 1", FailCount); end
    do_fail();
    checks++;
    if (FailCount !== 2'd2 || Lockout !== 1'b0) begin errors++; $display("FAIL fail_2: got fc=%0d lo=%0b expected 2 0", FailCount, Lockout); end
    do_fail();
    checks++;
    if (Lockout !== 1'b1 || LockReset !== 1'b1 || FailCount !== 2'd3) begin
      errors++; $display("FAIL lockout_entry: got lo=%0b lr=%0b fc=%0d expected 1 1 3", Lockout, LockReset, FailCount);
    end
    wait_lockout(1'b1, hi, pulses, lr_bad);
    checks++;
    if (hi !== 1000) begin errors++; $display("FAIL lockout_len: got %0d expected 1000", hi); end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL lockout_keys: got %0d pulses expected 0", pulses); end
    checks++;
    if (lr_bad !== 0) begin errors++; $display("FAIL lockout_lr: got %0d low cycles expected 0", lr_bad); end
    checks++;
    if (Lockout !== 1'b0 || FailCount !== 2'd0 || LockReset !== 1'b0 || Alarm !== 1'b0) begin
      errors++; $display("FAIL lockout_exit: got lo=%0b fc=%0d lr=%0b al=%0b expected 0 0 0 0", Lockout, FailCount, LockReset, Alarm);
    end
    tick();
  endtask

  task automatic test_success_relock();
    int k, pulses;
    do_fail(); do_fail();
    checks++;
    if (FailCount !== 2'd2) begin errors++; $display("FAIL pre_success: got %0d expected 2", FailCount); end
    LockState = 2'b01; tick();
    LockState = 2'b11; tick();
    checks++;
    if (FailCount !== 2'd0 || LockReset !== 1'b0) begin errors++; $display("FAIL open_entry: got fc=%0d lr=%0b expected 0 0", FailCount, LockReset); end
    k = 0; pulses = 0;
    for (int i = 1; i <= 600; i++) begin
      if (i == 50) Key1 = 1'b1;
      if (i == 60) Key1 = 1'b0;
      tick();
      if (Key1Pulse) pulses++;
      if (LockReset) begin k = i; break; end
    end
    checks++;
    if (k !== 500) begin errors++; $display("FAIL auto_relock_time: got %0d expected 500", k); end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL open_keys: got %0d pulses expected 0", pulses); end
    LockState = 2'b00;
    tick();
    checks++;
    if (LockReset !== 1'b0 || FailCount !== 2'd0) begin errors++; $display("FAIL relock_width: got lr=%0b fc=%0d expected 0 0", LockReset, FailCount); end
    repeat (3) tick();
  endtask

  task automatic test_manual_relock();
    int n;
    // Manual relock part-way through the timer.
    LockState = 2'b01; tick();
    LockState = 2'b11; tick();
    repeat (10) tick();
    ManualRelock = 1'b1; tick();
    ManualRelock = 1'b0;
    checks++;
    if (LockReset !== 1'b1) begin errors++; $display("FAIL manual_relock: got %0b expected 1", LockReset); end
    LockState = 2'b00; tick();
    checks++;
    if (LockReset !== 1'b0) begin errors++; $display("FAIL manual_relock_end: got %0b expected 0", LockReset); end
    repeat (3) tick();
    // Manual relock on the same cycle as timer expiry.
    LockState = 2'b01; tick();
    LockState = 2'b11; tick();
    repeat (499) tick();
    ManualRelock = 1'b1;
    n = 0;
    tick();
    ManualRelock = 1'b0;
    if (LockReset) n++;
    LockState = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (LockReset) n++;
    end
    checks++;
    if (n !== 1) begin errors++; $display("FAIL coincide_relock: got %0d pulse cycles expected 1", n); end
  endtask

  task automatic test_alarm();
    int hi, pulses, lr_bad;
    do_fail(); do_fail(); do_fail();
    checks++;
    if (Lockout !== 1'b1 || Alarm !== 1'b0) begin errors++; $display("FAIL lockout1: got lo=%0b al=%0b expected 1 0", Lockout, Alarm); end
    wait_lockout(1'b0, hi, pulses, lr_bad);
    tick();
    do_fail(); do_fail(); do_fail();
    checks++;
    if (Lockout !== 1'b1 || Alarm !== 1'b1) begin errors++; $display("FAIL lockout2_alarm: got lo=%0b al=%0b expected 1 1", Lockout, Alarm); end
    wait_lockout(1'b0, hi, pulses, lr_bad);
    checks++;
    if (Lockout !== 1'b0) begin errors++; $display("FAIL lockout2_exit: got %0b expected 0", Lockout); end
    tick();
    LockState = 2'b01; tick();
    LockState = 2'b11; tick();
    ManualRelock = 1'b1; tick();
    ManualRelock = 1'b0;
    LockState = 2'b00;
    repeat (3) tick();
    checks++;
    if (Alarm !== 1'b1) begin errors++; $display("FAIL alarm_sticky: got %0b expected 1", Alarm); end
  endtask

  task automatic test_reset_in_lockout();
    do_fail(); do_fail(); do_fail();
    checks++;
    if (Lockout !== 1'b1) begin errors++; $display("FAIL lockout3: got %0b expected 1", Lockout); end
    repeat (300) tick();
    Reset_n = 1'b0;
    tick();
    check_reset_values("reset_in_lockout");
    Reset_n = 1'b1;
    tick();
    checks++;
    if (LockReset !== 1'b0 || Lockout !== 1'b0 || Alarm !== 1'b0) begin
      errors++; $display("FAIL post_reset: got lr=%0b lo=%0b al=%0b expected 0 0 0", LockReset, Lockout, Alarm);
    end
  endtask

  initial begin
    test_reset();
    test_key_pulse();
    test_lockout();
    test_success_relock();
    test_manual_relock();
    test_alarm();
    test_reset_in_lockout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lock_access_controller.md
# lock_access_controller

Supervisory controller that sits between the raw push-buttons and `combination_lock_fsm`. It synchronizes and edge-detects the two key buttons into single-cycle pulses and watches the lock FSM's state to count failed entry attempts. After too many failures it enforces a timed lockout, and it re-locks an opened lock after a timeout or on request. A sticky alarm latches after repeated lockouts.

## Interface
- `MAX_FAILS`, 3: failed attempts that trigger lockout (≥1)
- `LOCKOUT_CYCLES`, 1000: lockout duration in clock cycles (≥2)
- `RELOCK_CYCLES`, 500: cycles the lock may stay open before auto-relock (≥2)
- `MAX_LOCKOUTS`, 2: lockouts without an intervening success that set `Alarm`
- `Clk`  in  1  system clock, rising edge
- `Reset_n`  in  1  synchronous, active-low reset
- `Key1`, `Key2`  in  1 each  raw asynchronous buttons
- `ManualRelock`  in  1  level request to relock while open
- `LockState`  in  2  state output of the lock FSM (00 idle, 01 first digit ok, 10 second ok, 11 open)
- `Key1Pulse`, `Key2Pulse`  out  1 each  one-cycle key strobes to the lock FSM
- `LockReset`  out  1  active-high reset to the lock FSM
- `FailCount`  out  $clog2(MAX_FAILS+1)  failures since last success or lockout exit
- `Lockout`  out  1  high while in LOCKOUT
- `Alarm`  out  1  sticky alarm

## Operation
- Each key passes through a 2-flop synchronizer, then a registered rising-edge detector. One press gives exactly one pulse, however long the key is held.
- Pulses are forwarded only in IDLE/ENTRY. In OPEN and LOCKOUT they are forced to 0, but the synchronizer and edge detector keep running, so a key held across a state exit does not produce a pulse.
- `LockState` is registered as `prev`. A failure is `prev`∈{01,10} and `LockState`=00 with no `LockReset` issued in the previous cycle. A success is `LockState`=11.
- FSM states:
  - IDLE: `LockState`=00. On 01, go to ENTRY.
  - ENTRY: on failure, increment `FailCount`. If it reaches `MAX_FAILS`, go to LOCKOUT; otherwise go to IDLE. On success, go to OPEN.
  - OPEN: clear `FailCount` and the lockout counter. Run the relock timer. On `ManualRelock`, or when the timer reaches `RELOCK_CYCLES`-1, pulse `LockReset` and go to IDLE.
  - LOCKOUT: `LockReset` is held high for the whole lockout and `FailCount` holds at `MAX_FAILS`. On entry, increment the lockout counter (saturating at `MAX_LOCKOUTS`) and set `Alarm` when it reaches `MAX_LOCKOUTS`. After `LOCKOUT_CYCLES` cycles, clear `FailCount` and go to IDLE.
- `Alarm` clears only on `Reset_n`=0.
- If `ManualRelock` and timer expiry occur in the same cycle, exactly one `LockReset` pulse is issued.
- Failure and success cannot coincide. Simultaneous `Key1Pulse`/`Key2Pulse` are both forwarded.

## Timing
- Reset values: `Key1Pulse`=`Key2Pulse`=0, `LockReset`=1, `FailCount`=0, `Lockout`=0, `Alarm`=0, FSM=IDLE, all counters 0.
- Synchronizer stages also clear on reset.
- A reset applied mid-operation (any state) takes effect at the next edge with the values above.
- `LockReset` stays high in the first cycle after `Reset_n` deasserts, so the lock FSM is cleared alongside this block.
- Key latency: with the key first sampled high at edge N, the pulse is high from edge N+2 to edge N+3.
- All outputs are registered.
- Failure to LOCKOUT: `Lockout` and `LockReset` rise one edge after the failure is detected. `Lockout` stays high exactly `LOCKOUT_CYCLES` cycles.
- Auto-relock: the `LockReset` pulse is 1 cycle wide and is asserted `RELOCK_CYCLES` cycles after OPEN entry.

## Structure
- Shared package `lock_pkg` holds:
  - the lock-state encodings (`LS_IDLE`=00 … `LS_OPEN`=11), which `combination_lock_fsm` also uses;
  - the controller state enum {IDLE, ENTRY, OPEN, LOCKOUT}.
- Sub-module `key_pulse_sync` (2-flop synchronizer plus edge detector), instantiated twice.
- Counter widths are derived with `$clog2` from the parameters.

## Test plan
- Reset, then hold `Key1` high for 20 cycles -> exactly one `Key1Pulse`, asserted at edge N+2. `LockReset`=1 for the first cycle after `Reset_n` rises.
- Drive `LockState` 00→01→00 three times (`MAX_FAILS`=3) -> `FailCount` 1,2; on the third failure `Lockout`=1 and `LockReset`=1 for 1000 cycles. Key presses during lockout -> no pulses. Afterwards `FailCount`=0.
- Two failures, then `LockState`→11 -> OPEN, `FailCount`=0, one `LockReset` pulse 500 cycles later.
- In OPEN, assert `ManualRelock` at cycle 499 of the timer (coinciding with expiry) -> exactly one `LockReset` pulse.
- Two full lockouts with no success (`MAX_LOCKOUTS`=2) -> `Alarm`=1. It remains 1 after a later success and clears only after `Reset_n`=0.
- `Reset_n`=0 during LOCKOUT cycle 300 -> all outputs return to their reset values on the next edge.
